clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Runtime-programmable, glitch-free clock-divider controller that sits beside `clock_gen` and drives the fabric's divided-clock and clock-enable nets from a single source clock. It accepts new divide ratios over a valid/ready handshake, applies them only at period boundaries so no runt pulse is ever produced, and starts and stops the divided output cleanly on an enable request. Downstream logic consumes `clk_en` as a one-cycle strobe, or `clk_out` as a square wave for observation.

## Interface
- `DIV_W`, default 8: width of divide-ratio fields.
- `RESET_DIV`, default 2: divide ratio loaded on reset. Must be ≥2.
- `clk_in`  in  1: source clock. All flops are rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: run request. Level-sensitive.
- `cfg_valid`  in  1: new ratio offered.
- `cfg_div`  in  DIV_W: requested divide ratio N.
- `cfg_ready`  out  1: controller can accept a ratio.
- `clk_out`  out  1: registered divided clock.
- `clk_en`  out  1: one-cycle strobe on the last cycle of each period.
- `cur_div`  out  DIV_W: ratio currently in effect.
- `cfg_err`  out  1: one-cycle pulse marking a rejected ratio.
- `period_count`  out  8: count of completed periods (see Configuration).

## Operation
- **Reset values:** state IDLE, `cnt`=0, pending empty, `cur_div`=RESET_DIV, `clk_out`=0, `clk_en`=0, `cfg_ready`=1, `cfg_err`=0, `period_count`=0.
- **State machine:**
  - IDLE → RUN when `enable`=1.
  - RUN → STOP when `enable`=0, unless the current cycle is a boundary; in that case go directly to IDLE.
  - STOP → RUN when `enable`=1, with the counter continuing.
  - STOP → IDLE at the boundary.
- **Counter:** `cnt` runs 0..`cur_div`-1 in RUN and STOP, wrapping to 0 after the boundary cycle (`cnt`==`cur_div`-1). In IDLE, `cnt` is held at 0.
- **clk_out:**
  - In RUN/STOP: `clk_out` = (`cnt` < `cur_div`>>1). For N=5 that is 2 cycles high, 3 low; for N=2, 1 high, 1 low.
  - In IDLE: `clk_out` = 0.
  - Must be a flop output, computed from next-state values.
- **clk_en:** high in the boundary cycle of RUN/STOP only.
- **Handshake:**
  - Transfer happens when `cfg_valid` && `cfg_ready`.
  - N<2 is rejected: `cfg_err`=1 for the next cycle, with no other effect. The transfer still completes.
  - In IDLE, a valid N is written to `cur_div` at the accepting edge. `cfg_ready` stays 1.
  - In RUN/STOP, a valid N is written to a pending register and `cfg_ready` drops to 0. At the next boundary, pending is copied to `cur_div` and the new period starts with the new N. `cfg_ready` returns to 1 on the cycle after that boundary.
- **Simultaneous events:**
  - A transfer in a boundary cycle applies at the following boundary, not the current one.
  - Pending applied at a STOP→IDLE boundary takes effect for the next run.
  - `enable` dropping and a pending apply at the same boundary are both honoured.
- **Mid-operation reset:** `rst` returns every output to its reset value immediately. The pending ratio is discarded.

## Timing
- `enable` sampled 1 at edge t in IDLE: after t, state is RUN, `cnt`=0, `clk_out`=1. Latency is 1 cycle.
- Stop latency: at most `cur_div` cycles. The final period always completes in full.
- `clk_en` lines up with the last cycle of each period. Period length is exactly `cur_div` cycles, with no short or stretched periods at reconfiguration.
- `cfg_err` asserts 1 cycle after the rejecting transfer.

## Configuration
- **`CLK_DIV_CTRL_PERIOD_CNT_EN` defined:** `period_count` increments on each `clk_en` cycle and wraps 255→0. It is cleared only by `rst`.
- **Macro undefined:** `period_count` is tied to 0 and no counter flops are synthesised.

## Structure
- **Shared package `clk_div_pkg`:** state enum (IDLE, RUN, STOP), `DIV_MIN`=2, and the default-width constant.
- **Sub-module `clk_div_period_cnt`:** instantiated only under the macro.

## Test plan
- **Reset and enable:** reset, then hold `enable`=1 with N=2. Required: `clk_out` toggles every cycle, `clk_en` pulses every 2nd cycle, and the first `clk_out`=1 appears 1 cycle after `enable`.
- **Odd ratio:** in IDLE, send N=5, then enable. Required: `clk_out` is 2 high / 3 low repeating, and `clk_en` is high on every 5th cycle.
- **Reconfiguration mid-period:** while running N=4, send N=6 at `cnt`=1. Required: `cfg_ready`=0 until the boundary, the current period completes as 4 cycles, the next period is 6 cycles, and `cur_div`=6.
- **Transfer at boundary:** send N=3 in the boundary cycle of N=4. Required: one more 4-cycle period runs before N=3 takes effect.
- **Invalid ratios:** send N=0, then N=1. Required: `cfg_err` pulses once for each, and `cur_div` is unchanged.
- **Stop and reset:** drop `enable` at `cnt`=0 of N=8. Required: 7 more cycles run, then IDLE with `clk_out`=0. Asserting `rst` mid-period clears all outputs. With the macro defined, 256 periods wrap `period_count` to 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clk_div_ctrl divider slice.
//   state_t   - controller state (IDLE, RUN, STOP)
//   DIV_MIN   - smallest divide ratio that is accepted
//   DIV_W_DEF - default width of divide-ratio fields
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam int DIV_MIN   = 2;
    localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/clk_div_period_cnt.sv
// clk_div_period_cnt: 8-bit wrapping count of completed divider periods.
//   clk_in - source clock
//   rst    - asynchronous active-high reset
//   inc    - one-cycle strobe marking the last cycle of a period
//   count  - number of completed periods, wraps 255 -> 0
module clk_div_period_cnt (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable glitch-free clock divider controller.
//   clk_in       - source clock (rising edge)
//   rst          - asynchronous active-high reset
//   enable       - level-sensitive run request
//   cfg_valid    - new divide ratio offered
//   cfg_div      - requested divide ratio N
//   cfg_ready    - controller can accept a ratio
//   clk_out      - registered divided clock
//   clk_en       - one-cycle strobe on the last cycle of each period
//   cur_div      - ratio currently in effect
//   cfg_err      - one-cycle pulse after a rejected ratio (N < 2)
//   period_count - completed periods; live only with CLK_DIV_CTRL_PERIOD_CNT_EN
//                  defined, otherwise tied to 0
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             cfg_err,
    output logic [7:0]       period_count
);

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, cur_div_n, pend_div, pend_div_n;
    logic             pend_v, pend_v_n;
    logic             boundary, xfer, bad, apply, clk_out_n, clk_en_n, cfg_err_n;

    // A pending ratio holds off further transfers until it is applied.
    assign cfg_ready = !pend_v;

    always_comb begin
        xfer       = cfg_valid && cfg_ready;
        bad        = cfg_div < DIV_W'(DIV_MIN);
        boundary   = (state != IDLE) && (cnt == cur_div - DIV_W'(1));
        apply      = boundary && pend_v;
        // Stopping always finishes the current period before reaching IDLE.
        state_n    = (state == IDLE) ? (enable ? RUN : IDLE)
                   : enable ? RUN : boundary ? IDLE : STOP;
        cnt_n      = (state == IDLE || boundary) ? '0 : cnt + DIV_W'(1);
        cur_div_n  = apply ? pend_div
                   : (state == IDLE && xfer && !bad) ? cfg_div : cur_div;
        pend_v_n   = apply ? 1'b0 : (state != IDLE && xfer && !bad) ? 1'b1 : pend_v;
        pend_div_n = (state != IDLE && xfer && !bad) ? cfg_div : pend_div;
        cfg_err_n  = xfer && bad;
        // Outputs are computed from next-state values so they can be flopped
        // without adding a cycle of lag to the period.
        clk_out_n  = (state_n != IDLE) && (cnt_n < (cur_div_n >> 1));
        clk_en_n   = (state_n != IDLE) && (cnt_n == cur_div_n - DIV_W'(1));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= DIV_W'(RESET_DIV);
            pend_v   <= 1'b0;
            pend_div <= '0;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_div  <= cur_div_n;
            pend_v   <= pend_v_n;
            pend_div <= pend_div_n;
            clk_out  <= clk_out_n;
            clk_en   <= clk_en_n;
            cfg_err  <= cfg_err_n;
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    clk_div_period_cnt u_period_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (clk_en),
        .count  (period_count)
    );
`else
    assign period_count = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl.
module tb_clk_div_ctrl;

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst, enable, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, clk_out, clk_en, cfg_err;
    logic [7:0] cur_div, period_count;

    typedef struct {
        logic       co;
        logic       ce;
        logic [7:0] cd;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_pc = '0;
    int         n_tests = 0;
    int         n_fail = 0;

    clk_div_ctrl dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .clk_out      (clk_out),
        .clk_en       (clk_en),
        .cur_div      (cur_div),
        .cfg_err      (cfg_err),
        .period_count (period_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_e(input logic co, input logic ce, input int cd, input logic rdy, input logic err);
        sb.push_back('{co: co, ce: ce, cd: 8'(cd), rdy: rdy, err: err});
    endtask

    // One period of ratio n from cnt=start; entries with cnt >= nrdy expect cfg_ready=0.
    task automatic push_period(input int n, input int start, input int nrdy, input logic err);
        for (int i = start; i < n; i++)
            push_e(i < n / 2, i == n - 1, n, i < nrdy, err && i == start);
    endtask

    task automatic push_idle(input int cd);
        push_e(1'b0, 1'b0, cd, 1'b1, 1'b0);
    endtask

    task automatic run(input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            @(posedge clk_in);
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
                continue;
            end
            e = sb.pop_front();
            check("clk_out", clk_out, e.co);
            check("clk_en", clk_en, e.ce);
            check("cur_div", cur_div, e.cd);
            check("cfg_ready", cfg_ready, e.rdy);
            check("cfg_err", cfg_err, e.err);
            check("period_count", period_count, exp_pc);
            if (PC_EN && e.ce)
                exp_pc++;
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_clk_out"}, clk_out, 0);
        check({tag, "_clk_en"}, clk_en, 0);
        check({tag, "_cur_div"}, cur_div, 2);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_period_count"}, period_count, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        // N=2 free-running, then stop at a boundary
        enable = 1'b1;
        repeat (3) push_period(2, 0, 2, 1'b0);
        run(6);
        enable = 1'b0; push_idle(2); run(1);
        // odd ratio N=5 programmed in IDLE
        cfg_valid = 1'b1; cfg_div = 8'd5; push_idle(5); run(1); cfg_valid = 1'b0;
        enable = 1'b1;
        repeat (2) push_period(5, 0, 5, 1'b0);
        run(10);
        enable = 1'b0; push_idle(5); run(1);
        // N=4 running, N=6 sent at cnt=1
        cfg_valid = 1'b1; cfg_div = 8'd4; push_idle(4); run(1); cfg_valid = 1'b0;
        enable = 1'b1;
        push_period(4, 0, 2, 1'b0);
        push_period(6, 0, 6, 1'b0);
        run(2);
        cfg_valid = 1'b1; cfg_div = 8'd6; run(1); cfg_valid = 1'b0; run(7);
        // transfers in boundary cycles wait one extra period
        push_period(6, 0, 0, 1'b0);
        push_period(4, 0, 4, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd4; run(1); cfg_valid = 1'b0; run(9);
        push_period(4, 0, 0, 1'b0);
        push_period(3, 0, 3, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd3; run(1); cfg_valid = 1'b0; run(6);
        // invalid ratios N=0 and N=1
        push_e(1'b1, 1'b0, 3, 1'b1, 1'b1);
        push_e(1'b0, 1'b0, 3, 1'b1, 1'b0);
        push_e(1'b0, 1'b1, 3, 1'b1, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd0; run(1);
        cfg_valid = 1'b0; run(1);
        cfg_valid = 1'b1; cfg_div = 8'd1; run(1);
        cfg_valid = 1'b0;
        // switch to N=8, then drop enable at cnt=0
        push_period(3, 0, 0, 1'b0);
        push_e(1'b1, 1'b0, 8, 1'b1, 1'b0);
        cfg_valid = 1'b1; cfg_div = 8'd8; run(1); cfg_valid = 1'b0; run(3);
        enable = 1'b0;
        push_period(8, 1, 8, 1'b0);
        push_idle(8); push_idle(8);
        run(9);
        // reset mid-period with a ratio pending
        enable = 1'b1;
        push_e(1'b1, 1'b0, 8, 1'b1, 1'b0);
        push_e(1'b1, 1'b0, 8, 1'b1, 1'b0);
        push_e(1'b1, 1'b0, 8, 1'b0, 1'b0);
        run(2);
        cfg_valid = 1'b1; cfg_div = 8'd5; run(1); cfg_valid = 1'b0;
        #2 rst = 1'b1; enable = 1'b0;
        #1;
        chk_reset("mid_rst");
        exp_pc = '0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) push_period(2, 0, 2, 1'b0);
        run(4);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        repeat (254) push_period(2, 0, 2, 1'b0);
        run(508);
        push_e(1'b1, 1'b0, 2, 1'b1, 1'b0);
        run(1);
        check("pc_wrap", period_count, 0);
`endif
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
